axi4_write_arbiter: RTL and testbench



---
 rtl/axi4_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi4_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 write-burst engine between NUM_REQ writers.
// Latches the winner's job fields, starts the engine, and returns done/error per requester.
module axi4_write_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int REQ_IDX_WIDTH       = 2,
  parameter int AXI_ADDR_WIDTH      = 32,
  parameter int TRAN_BYTE_NUM_WIDTH = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_REQ-1:0]                     req_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQ*TRAN_BYTE_NUM_WIDTH-1:0] req_byte_num_i,
  output logic [NUM_REQ-1:0]                     ack_o,
  output logic [NUM_REQ-1:0]                     done_o,
  output logic [NUM_REQ-1:0]                     error_o,
  output logic [NUM_REQ-1:0]                     grant_o,
  output logic [REQ_IDX_WIDTH-1:0]               grant_idx_o,
  output logic                                   busy_o,
  output logic                                   w_start_o,
  output logic [AXI_ADDR_WIDTH-1:0]              w_target_slave_base_addr_o,
  output logic [TRAN_BYTE_NUM_WIDTH-1:0]         w_total_byte_num_o,
  input  logic                                   w_busy_i,
  input  logic                                   w_error_i
);

  // state     | meaning
  // IDLE      | no job; arbitrate pending requests
  // START     | w_start_o and ack_o pulse for the granted job
  // WAIT_BUSY | engine started, waiting for its busy flag
  // WAIT_DONE | engine running, waiting for busy to drop
  // DONE      | done_o/error_o pulse, pointer advances
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                           state, state_next;
  logic [REQ_IDX_WIDTH-1:0]         ptr, ptr_next;
  logic [REQ_IDX_WIDTH-1:0]         win, hi_win, lo_win, idx_next;
  logic                             found, hi_found, load;
  logic [NUM_REQ-1:0]               win_oh, own_oh;
  logic [AXI_ADDR_WIDTH-1:0]        sel_addr;
  logic [TRAN_BYTE_NUM_WIDTH-1:0]   sel_bytes;
  logic                             busy_q, error_q;
  logic                             start_next;
  logic [NUM_REQ-1:0]               ack_next, done_next, error_next, grant_next;

  // Lowest set bit above the pointer wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    hi_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_win = REQ_IDX_WIDTH'(i);
        if (i > int'(ptr)) begin
          hi_found = 1'b1;
          hi_win   = REQ_IDX_WIDTH'(i);
        end
      end
    end
    found = |req_i;
    win   = hi_found ? hi_win : lo_win;
  end

  always_comb begin
    sel_addr  = '0;
    sel_bytes = '0;
    win_oh    = '0;
    own_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == REQ_IDX_WIDTH'(i)) begin
        win_oh[i] = 1'b1;
        sel_addr  = req_addr_i[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_bytes = req_byte_num_i[i*TRAN_BYTE_NUM_WIDTH +: TRAN_BYTE_NUM_WIDTH];
      end
      if (grant_idx_o == REQ_IDX_WIDTH'(i)) own_oh[i] = 1'b1;
    end
  end

  // Engine status is registered at the boundary, so done_o lands two cycles after busy falls.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    idx_next   = grant_idx_o;
    grant_next = grant_o;
    ack_next   = '0;
    done_next  = '0;
    error_next = '0;
    start_next = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          load       = 1'b1;
          idx_next   = win;
          grant_next = win_oh;
          ack_next   = win_oh;
          if (sel_bytes != '0) begin
            state_next = START;
            start_next = 1'b1;
          end else begin
            state_next = DONE;
            done_next  = win_oh;
          end
        end
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (busy_q) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!busy_q) begin
          state_next = DONE;
          done_next  = own_oh;
          error_next = error_q ? own_oh : '0;
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        ptr_next   = grant_idx_o;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr                        <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      busy_q                     <= 1'b0;
      error_q                    <= 1'b0;
      ack_o                      <= '0;
      done_o                     <= '0;
      error_o                    <= '0;
      grant_o                    <= '0;
      grant_idx_o                <= '0;
      busy_o                     <= 1'b0;
      w_start_o                  <= 1'b0;
      w_target_slave_base_addr_o <= '0;
      w_total_byte_num_o         <= '0;
    end else begin
      ptr         <= ptr_next;
      busy_q      <= w_busy_i;
      error_q     <= w_error_i;
      ack_o       <= ack_next;
      done_o      <= done_next;
      error_o     <= error_next;
      grant_o     <= grant_next;
      grant_idx_o <= idx_next;
      busy_o      <= (state_next != IDLE);
      w_start_o   <= start_next;
      if (load) begin
        w_target_slave_base_addr_o <= sel_addr;
        w_total_byte_num_o         <= sel_bytes;
      end
    end
  end

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Directed bench for axi4_write_arbiter: single job, round-robin order, zero-length,
// error return, delayed engine start and mid-job reset, with a simple engine model.
module tb_axi4_write_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] addr_bus;
  logic [63:0]  bytes_bus;
  logic [3:0]   ack_o, done_o, error_o, grant_o;
  logic [1:0]   grant_idx_o;
  logic         busy_o, w_start_o;
  logic [31:0]  w_addr;
  logic [15:0]  w_bytes;
  logic         w_busy = 1'b0;
  logic         w_error = 1'b0;

  logic [31:0]  addr_tab [4];
  logic [15:0]  bytes_tab [4];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign addr_bus[g*32 +: 32]  = addr_tab[g];
    assign bytes_bus[g*16 +: 16] = bytes_tab[g];
  end

  axi4_write_arbiter #(
    .NUM_REQ(4), .REQ_IDX_WIDTH(2), .AXI_ADDR_WIDTH(32), .TRAN_BYTE_NUM_WIDTH(16)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .req_i                      (req),
    .req_addr_i                 (addr_bus),
    .req_byte_num_i             (bytes_bus),
    .ack_o                      (ack_o),
    .done_o                     (done_o),
    .error_o                    (error_o),
    .grant_o                    (grant_o),
    .grant_idx_o                (grant_idx_o),
    .busy_o                     (busy_o),
    .w_start_o                  (w_start_o),
    .w_target_slave_base_addr_o (w_addr),
    .w_total_byte_num_o         (w_bytes),
    .w_busy_i                   (w_busy),
    .w_error_i                  (w_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ack"},   ack_o, 0);
    check_val({tag, "_done"},  done_o, 0);
    check_val({tag, "_err"},   error_o, 0);
    check_val({tag, "_grant"}, grant_o, 0);
    check_val({tag, "_gidx"},  grant_idx_o, 0);
    check_val({tag, "_busy"},  busy_o, 0);
    check_val({tag, "_start"}, w_start_o, 0);
    check_val({tag, "_addr"},  w_addr, 0);
    check_val({tag, "_bytes"}, w_bytes, 0);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    w_busy = 1'b0;
    w_error = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Waits for the start pulse, checks the latched job, then plays the engine.
  task automatic serve_job(input int id, input int delay, input int busy_cyc,
                           input bit err, input logic [3:0] req_after);
    logic [3:0] oh;
    int k;
    oh = 4'b0001 << id;
    k  = 0;
    while (!w_start_o && k < 8) begin
      tick();
      k++;
    end
    check_val("start_pulse", w_start_o, 1);
    check_val("ack", ack_o, oh);
    check_val("grant", grant_o, oh);
    check_val("grant_idx", grant_idx_o, id);
    check_val("addr", w_addr, addr_tab[id]);
    check_val("bytes", w_bytes, bytes_tab[id]);
    req = req_after;
    tick();
    check_val("start_once", w_start_o, 0);
    check_val("ack_once", ack_o, 0);
    for (int d = 0; d < delay; d++) begin
      tick();
      check_val("wait_busy_done", done_o, 0);
      check_val("wait_busy_start", w_start_o, 0);
      check_val("wait_busy_busy", busy_o, 1);
    end
    w_busy  = 1'b1;
    w_error = 1'b0;
    repeat (busy_cyc) tick();
    w_error = err;
    w_busy  = 1'b0;
    tick();
    check_val("done_early", done_o, 0);
    tick();
    check_val("done", done_o, oh);
    check_val("error", error_o, err ? oh : 4'b0000);
    check_val("grant_in_done", grant_o, oh);
    w_error = 1'b0;
    tick();
    check_val("idle_busy", busy_o, 0);
    check_val("idle_grant", grant_o, 0);
    check_val("idle_gidx_hold", grant_idx_o, id);
    check_val("idle_done", done_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_tab[i]  = 32'h1000_0000 + 32'(i) * 32'h0100_0000;
      bytes_tab[i] = 16'(1024 >> i);
    end

    do_reset();

    // single job, 20 busy cycles
    req = 4'b0001;
    serve_job(0, 0, 20, 1'b0, 4'b0000);

    // round robin from a fresh pointer
    do_reset();
    req = 4'b1111;
    serve_job(0, 0, 3, 1'b0, 4'b1111);
    serve_job(1, 0, 3, 1'b0, 4'b1111);
    serve_job(2, 0, 3, 1'b0, 4'b1111);
    serve_job(3, 0, 3, 1'b0, 4'b1111);
    serve_job(0, 0, 3, 1'b0, 4'b1111);
    serve_job(1, 0, 3, 1'b0, 4'b1001);
    serve_job(3, 0, 3, 1'b0, 4'b0000);

    // zero-length job for requester 2
    bytes_tab[2] = 16'd0;
    req = 4'b0100;
    tick();
    check_val("zl_ack", ack_o, 4'b0100);
    check_val("zl_done", done_o, 4'b0100);
    check_val("zl_grant", grant_o, 4'b0100);
    check_val("zl_error", error_o, 4'b0000);
    check_val("zl_start", w_start_o, 0);
    check_val("zl_bytes", w_bytes, 0);
    check_val("zl_addr", w_addr, addr_tab[2]);
    req = 4'b0000;
    tick();
    check_val("zl_idle_start", w_start_o, 0);
    check_val("zl_idle_grant", grant_o, 0);
    check_val("zl_idle_busy", busy_o, 0);
    bytes_tab[2] = 16'(1024 >> 2);

    // error returned, then a clean job
    req = 4'b0010;
    serve_job(1, 0, 4, 1'b1, 4'b0000);
    req = 4'b0010;
    serve_job(1, 0, 4, 1'b0, 4'b0000);

    // engine takes 5 cycles to raise busy
    req = 4'b0001;
    serve_job(0, 5, 3, 1'b0, 4'b0000);

    // reset while the engine is running
    req = 4'b0001;
    begin
      int k;
      k = 0;
      while (!w_start_o && k < 8) begin
        tick();
        k++;
      end
    end
    check_val("rst_job_start", w_start_o, 1);
    req = 4'b0000;
    tick();
    w_busy = 1'b1;
    repeat (4) tick();
    check_val("rst_job_running", busy_o, 1);
    #2;
    rst_n  = 1'b0;
    w_busy = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("post_rst_done", done_o, 0);
    check_val("post_rst_busy", busy_o, 0);
    req = 4'b0010;
    serve_job(1, 0, 2, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
